dsa_mem_arbiter: RTL and testbench
==================================

# dsa_mem_arbiter

N-port handshake arbiter that lets several bilinear cores (sequential, SIMD4, future variants) share one single-port wide on-chip memory with valid/ready requests and in-order responses. It replaces the static mode-select mux in front of the input memory. It provides round-robin or fixed-priority arbitration, an optional exclusive-lock mode, a bounded outstanding-read tracker, and per-port response routing. It sits between the core request interfaces and `wide_onchip_mem`.

## Interface
Parameters:
- `N_PORTS`, 2: number of requester ports (2..8).
- `AW`, 18: word address width.
- `DW`, 32: data width (4 pixels per word at 32).
- `MAX_OUTST`, 4: maximum outstanding reads (power of two, 2..16).
- `ARB_MODE`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `s_req_valid`  in  N_PORTS  per-port request valid.
- `s_req_ready`  out  N_PORTS  per-port request accepted this cycle.
- `s_req_we`  in  N_PORTS  per-port write enable.
- `s_req_addr`  in  N_PORTS×AW  per-port word address, packed.
- `s_req_wdata`  in  N_PORTS×DW  per-port write data, packed.
- `s_resp_valid`  out  N_PORTS  read response for that port.
- `s_resp_rdata`  out  DW  response data, broadcast to all ports.
- `i_lock_en`  in  1  exclusive mode; only `i_lock_port` may be granted.
- `i_lock_port`  in  clog2(N_PORTS)  locked port index.
- `m_req_valid`, `m_req_we`, `m_req_addr`, `m_req_wdata`  out  1/1/AW/DW  memory request.
- `m_req_ready`  in  1  memory accepts request.
- `m_resp_valid`  in  1  memory read response (reads only; writes produce none).
- `m_resp_rdata`  in  DW  memory read data.
- `o_busy`  out  1  outstanding count ≠ 0.
- `o_err_orphan`  out  1  sticky flag: a response arrived with no tracked read.

## Operation
- Eligible set = `s_req_valid` masked by lock (only `i_lock_port` when `i_lock_en`=1). A grant is suppressed when the tracker is full and the eligible winner is a read. Writes are granted even when the tracker is full.
- Winner selection:
  - RR: first eligible index at or after `rr_ptr`, circularly.
  - Fixed: lowest eligible index.
- `m_req_*` carries the winner's fields. `m_req_valid` = winner exists.
- Handshake: `s_req_ready[w]` = `m_req_ready` & winner is `w`. All other ready bits are 0.
- On an accepted read: push `w` into the tag FIFO. On an accepted write: no push.
- On accept in RR mode: `rr_ptr` ← (w+1) mod N_PORTS. `rr_ptr` is unchanged when no accept occurs, and in fixed mode.
- On `m_resp_valid`:
  - Pop the FIFO head `h`.
  - Assert `s_resp_valid[h]`. `s_resp_rdata` = `m_resp_rdata`.
  - If the FIFO is empty: drop the response and set `o_err_orphan`.
- Simultaneous push and pop: both occur and the count is unchanged. The full check uses the registered count, so a read is blocked when full even if a pop happens the same cycle.
- Lock changes take effect combinationally. In-flight responses still route to their original port.
- Requesters must hold `valid`/`addr`/`we`/`wdata` stable until ready. This is not checked.

## Timing
- Request path is combinational: zero added latency, accept in the same cycle as `m_req_ready`.
- Response path is combinational from `m_resp_valid`: zero added latency.
- Reset (async assert): tag FIFO emptied, count=0, `rr_ptr`=0, `o_err_orphan`=0, `o_busy`=0.
- During reset: all `s_req_ready`=0, all `s_resp_valid`=0, `m_req_valid`=0.
- Reset mid-operation: outstanding tags are lost. Later memory responses are orphans; they are dropped and set `o_err_orphan`.
- Count width is clog2(MAX_OUTST)+1. Full when count == MAX_OUTST. Pointers wrap mod MAX_OUTST.

## Structure
- Package `dsa_mem_pkg`: `arb_mode_e` (ARB_RR, ARB_FIXED) and port-index width localparam helpers. Shared with the cores and top.
- Sub-module `dsa_tag_fifo`: synchronous FIFO with width clog2(N_PORTS) and depth MAX_OUTST. It has push/pop/full/empty/count and combinational head.
- Arbiter, lock mask, and routing live in `dsa_mem_arbiter`.

## Test plan
- RR, N=2, both ports issue continuous reads, memory always ready with 1-cycle response → grants alternate 0,1,0,1. Each port receives exactly its own rdata in order.
- Fixed mode, ports 0 and 1 both valid → port 0 granted every cycle and port 1 starved. When port 0 drops valid, port 1 is granted the same cycle.
- MAX_OUTST=4, memory withholds responses → 4 reads accepted, 5th read stalls with `s_req_ready`=0, and a write is still accepted. One response, then a read is accepted the following cycle.
- `i_lock_en`=1, `i_lock_port`=1, port 0 valid only → no grant. Unlock → port 0 granted the same cycle.
- Reset asserted with 3 reads outstanding, then 3 memory responses → no `s_resp_valid`, `o_err_orphan`=1, `o_busy`=0.
- Push and pop in the same cycle at count=2 → count stays 2 and the response routes to the oldest tag.

Source files
------------

// File: rtl/dsa_mem_pkg.sv
// Shared types and width helpers for the DSA memory arbiter and the cores that
// sit in front of wide_onchip_mem.
package dsa_mem_pkg;

  typedef enum logic [0:0] {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Port-index width; kept at least 1 bit so a single-port build still has a field.
  function automatic int port_idx_w(input int n_ports);
    return (n_ports > 1) ? $clog2(n_ports) : 1;
  endfunction

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dsa_tag_fifo.sv
// Tag FIFO holding the requester index of each outstanding read, oldest at head.
// Head is combinational so a memory response can be routed in the same cycle.
module dsa_tag_fifo
  import dsa_mem_pkg::*;
#(
  parameter  int W     = 1,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/dsa_mem_arbiter.sv
// N-port arbiter sharing one single-port wide memory: round-robin or fixed
// priority, optional exclusive lock, bounded outstanding reads, in-order response routing.
module dsa_mem_arbiter
  import dsa_mem_pkg::*;
#(
  parameter  int N_PORTS   = 2,
  parameter  int AW        = 18,
  parameter  int DW        = 32,
  parameter  int MAX_OUTST = 4,
  parameter  int ARB_MODE  = 0,
  localparam int PIW       = port_idx_w(N_PORTS),
  localparam int CNT_W     = cnt_w(MAX_OUTST)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_PORTS-1:0]    s_req_valid,
  output logic [N_PORTS-1:0]    s_req_ready,
  input  logic [N_PORTS-1:0]    s_req_we,
  input  logic [N_PORTS*AW-1:0] s_req_addr,
  input  logic [N_PORTS*DW-1:0] s_req_wdata,
  output logic [N_PORTS-1:0]    s_resp_valid,
  output logic [DW-1:0]         s_resp_rdata,
  input  logic                  i_lock_en,
  input  logic [PIW-1:0]        i_lock_port,
  output logic                  m_req_valid,
  output logic                  m_req_we,
  output logic [AW-1:0]         m_req_addr,
  output logic [DW-1:0]         m_req_wdata,
  input  logic                  m_req_ready,
  input  logic                  m_resp_valid,
  input  logic [DW-1:0]         m_resp_rdata,
  output logic                  o_busy,
  output logic                  o_err_orphan
);

  localparam bit FIXED_PRIO = (ARB_MODE == int'(ARB_FIXED));

  logic [N_PORTS-1:0] lock_mask;
  logic [N_PORTS-1:0] eligible;
  logic [PIW-1:0]     rr_ptr;
  logic [PIW-1:0]     cand_idx;
  logic [PIW-1:0]     win_idx;
  logic [PIW-1:0]     tag_head;
  logic               win_found;
  logic               win_is_read;
  logic               read_blocked;
  logic               accept;
  logic               resp_hit;
  logic               tag_full;
  logic               tag_empty;
  logic [CNT_W-1:0]   tag_count;

  always_comb begin
    lock_mask = {N_PORTS{1'b1}};
    if (i_lock_en) lock_mask = N_PORTS'(1) << i_lock_port;
  end

  assign eligible = rst ? '0 : (s_req_valid & lock_mask);

  // Scan starts at rr_ptr (round-robin) or at index 0 (fixed priority).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      cand_idx = FIXED_PRIO ? PIW'(k) : PIW'((int'(rr_ptr) + k) % N_PORTS);
      if (!win_found && eligible[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Handshake: a request transfers in the cycle where valid and ready are both
  // high on the same side; s_req_ready[w] mirrors m_req_ready for the winner
  // only. A full tracker holds off a winning read but never a winning write.
  assign win_is_read  = !s_req_we[win_idx];
  assign read_blocked = tag_full && win_is_read;
  assign m_req_valid  = win_found && !read_blocked;
  assign m_req_we     = s_req_we[win_idx];
  assign m_req_addr   = s_req_addr[win_idx*AW +: AW];
  assign m_req_wdata  = s_req_wdata[win_idx*DW +: DW];
  assign accept       = m_req_valid && m_req_ready;
  assign s_req_ready  = accept ? (N_PORTS'(1) << win_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept && !FIXED_PRIO) begin
      rr_ptr <= (int'(win_idx) == N_PORTS - 1) ? '0 : win_idx + PIW'(1);
    end
  end

  // Responses come back in issue order, so the oldest tag names the owner.
  assign resp_hit     = m_resp_valid && !tag_empty && !rst;
  assign s_resp_valid = resp_hit ? (N_PORTS'(1) << tag_head) : '0;
  assign s_resp_rdata = m_resp_rdata;

  dsa_tag_fifo #(
    .W     (PIW),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept && win_is_read),
    .din   (win_idx),
    .pop   (resp_hit),
    .head  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_err_orphan <= 1'b0;
    end else if (m_resp_valid && tag_empty) begin
      o_err_orphan <= 1'b1;
    end
  end

  assign o_busy = (tag_count != '0);

endmodule

// File: tb/tb_dsa_mem_arbiter.sv
// Randomized bench for dsa_mem_arbiter: a round-robin and a fixed-priority
// instance run against a queue-based reference model and a response scoreboard.
module tb_dsa_mem_arbiter;
  import dsa_mem_pkg::*;

  localparam int NP = 3;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int PW = 2;
  localparam int NI = 2;
  localparam int EW = PW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0]    s_req_valid  [NI];
  logic [NP-1:0]    s_req_ready  [NI];
  logic [NP-1:0]    s_req_we     [NI];
  logic [NP*AW-1:0] s_req_addr   [NI];
  logic [NP*DW-1:0] s_req_wdata  [NI];
  logic [NP-1:0]    s_resp_valid [NI];
  logic [DW-1:0]    s_resp_rdata [NI];
  logic             lock_en      [NI];
  logic [PW-1:0]    lock_port    [NI];
  logic             m_req_valid  [NI];
  logic             m_req_we     [NI];
  logic [AW-1:0]    m_req_addr   [NI];
  logic [DW-1:0]    m_req_wdata  [NI];
  logic             m_req_ready  [NI];
  logic             m_resp_valid [NI];
  logic [DW-1:0]    m_resp_rdata [NI];
  logic             busy         [NI];
  logic             orphan       [NI];

  // Instance 0 is round-robin, instance 1 is fixed priority.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    dsa_mem_arbiter #(
      .N_PORTS(NP), .AW(AW), .DW(DW), .MAX_OUTST(MO), .ARB_MODE(g)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .s_req_valid  (s_req_valid[g]),
      .s_req_ready  (s_req_ready[g]),
      .s_req_we     (s_req_we[g]),
      .s_req_addr   (s_req_addr[g]),
      .s_req_wdata  (s_req_wdata[g]),
      .s_resp_valid (s_resp_valid[g]),
      .s_resp_rdata (s_resp_rdata[g]),
      .i_lock_en    (lock_en[g]),
      .i_lock_port  (lock_port[g]),
      .m_req_valid  (m_req_valid[g]),
      .m_req_we     (m_req_we[g]),
      .m_req_addr   (m_req_addr[g]),
      .m_req_wdata  (m_req_wdata[g]),
      .m_req_ready  (m_req_ready[g]),
      .m_resp_valid (m_resp_valid[g]),
      .m_resp_rdata (m_resp_rdata[g]),
      .o_busy       (busy[g]),
      .o_err_orphan (orphan[g])
    );
  end

  // ---------------- requester / memory / model state ----------------
  bit            req_v    [NI][NP];
  bit            req_we   [NI][NP];
  int            req_addr [NI][NP];
  logic [DW-1:0] req_wd   [NI][NP];

  logic [DW-1:0] mem_model [NI][16];
  logic [DW-1:0] mem_rq    [NI][$];  // data the memory still owes, oldest first
  int            m_tags    [NI][$];  // requester of each tracked read, oldest first
  int            m_rr      [NI];
  bit            m_orph    [NI];
  logic [EW-1:0] exp_q     [NI][$];  // {port, rdata} due on s_resp this cycle

  int n_checks = 0;
  int n_fail   = 0;

  int req_pct = 60, we_pct = 30, ready_pct = 80, resp_pct = 50;
  int lock_pct = 0, spur_pct = 0, rst_permille = 0;
  bit force_rst = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    rst = force_rst || ($urandom_range(999) < rst_permille);
    for (int i = 0; i < NI; i++) begin
      for (int p = 0; p < NP; p++) begin
        if (!req_v[i][p] && $urandom_range(99) < req_pct) begin
          req_v[i][p]    = 1'b1;
          req_we[i][p]   = ($urandom_range(99) < we_pct);
          req_addr[i][p] = $urandom_range(15);
          req_wd[i][p]   = $urandom;
        end
        s_req_valid[i][p]            = req_v[i][p];
        s_req_we[i][p]               = req_we[i][p];
        s_req_addr[i][p*AW +: AW]    = AW'(req_addr[i][p]);
        s_req_wdata[i][p*DW +: DW]   = req_wd[i][p];
      end
      lock_en[i]     = ($urandom_range(99) < lock_pct);
      lock_port[i]   = PW'($urandom_range(NP - 1));
      m_req_ready[i] = ($urandom_range(99) < ready_pct);
      m_resp_valid[i] = 1'b0;
      m_resp_rdata[i] = $urandom;
      if (!rst) begin
        if (mem_rq[i].size() > 0 && $urandom_range(99) < resp_pct) begin
          m_resp_valid[i] = 1'b1;
          m_resp_rdata[i] = mem_rq[i].pop_front();
        end else if (mem_rq[i].size() == 0 && $urandom_range(99) < spur_pct) begin
          m_resp_valid[i] = 1'b1;
        end
      end
    end
  endtask

  // ---------------- reference model + request-side checks ----------------
  task automatic model_check();
    for (int i = 0; i < NI; i++) begin
      logic [NP-1:0] exp_rdy;
      int  w;
      bit  found;
      bit  exp_mv;
      if (rst) begin
        check($sformatf("rst_ready%0d", i), s_req_ready[i], 0);
        check($sformatf("rst_mvalid%0d", i), m_req_valid[i], 0);
        check($sformatf("rst_busy%0d", i), busy[i], 0);
        check($sformatf("rst_orphan%0d", i), orphan[i], 0);
        m_tags[i].delete();
        m_rr[i]   = 0;
        m_orph[i] = 1'b0;
        continue;
      end
      check($sformatf("busy%0d", i), busy[i], m_tags[i].size() != 0);
      check($sformatf("orphan%0d", i), orphan[i], m_orph[i]);

      found = 1'b0;
      w     = 0;
      for (int k = 0; k < NP; k++) begin
        int c;
        c = (i == 1) ? k : (m_rr[i] + k) % NP;
        if (!found && req_v[i][c] && (!lock_en[i] || int'(lock_port[i]) == c)) begin
          found = 1'b1;
          w     = c;
        end
      end
      exp_mv = found && !(m_tags[i].size() == MO && !req_we[i][w]);
      check($sformatf("m_req_valid%0d", i), m_req_valid[i], exp_mv);
      if (exp_mv) begin
        check($sformatf("m_req_we%0d", i), m_req_we[i], req_we[i][w]);
        check($sformatf("m_req_addr%0d", i), m_req_addr[i], AW'(req_addr[i][w]));
        check($sformatf("m_req_wdata%0d", i), m_req_wdata[i], req_wd[i][w]);
      end
      exp_rdy = (exp_mv && m_req_ready[i]) ? (NP'(1) << w) : '0;
      check($sformatf("s_req_ready%0d", i), s_req_ready[i], exp_rdy);

      // Response pops the oldest tracked read before this cycle's push lands.
      if (m_resp_valid[i]) begin
        if (m_tags[i].size() > 0) exp_q[i].push_back({PW'(m_tags[i].pop_front()), m_resp_rdata[i]});
        else                      m_orph[i] = 1'b1;
      end

      if (exp_mv && m_req_ready[i]) begin
        req_v[i][w] = 1'b0;
        if (req_we[i][w]) begin
          mem_model[i][req_addr[i][w]] = req_wd[i][w];
        end else begin
          m_tags[i].push_back(w);
          mem_rq[i].push_back(mem_model[i][req_addr[i][w]]);
        end
        if (i == 0) m_rr[i] = (w + 1) % NP;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      model_check();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (exp_q[i].size() > 0) begin
          logic [EW-1:0] e;
          e = exp_q[i].pop_front();
          check($sformatf("resp_port%0d", i), s_resp_valid[i], NP'(1) << e[EW-1:DW]);
          check($sformatf("resp_data%0d", i), s_resp_rdata[i], e[DW-1:0]);
        end else begin
          check($sformatf("resp_idle%0d", i), s_resp_valid[i], 0);
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < NI; i++) begin
      for (int a = 0; a < 16; a++) mem_model[i][a] = $urandom;
      for (int p = 0; p < NP; p++) begin
        req_v[i][p] = 1'b0; req_we[i][p] = 1'b0; req_addr[i][p] = 0; req_wd[i][p] = '0;
      end
      s_req_valid[i] = '0; s_req_we[i] = '0; s_req_addr[i] = '0; s_req_wdata[i] = '0;
      lock_en[i] = 1'b0; lock_port[i] = '0; m_req_ready[i] = 1'b0;
      m_resp_valid[i] = 1'b0; m_resp_rdata[i] = '0;
      m_rr[i] = 0; m_orph[i] = 1'b0;
    end

    force_rst = 1'b1;
    run(3);
    force_rst = 1'b0;

    // Mixed traffic, memory randomly ready and responding.
    run(400);

    // Tracker fills: reads stall at MAX_OUTST while writes keep flowing.
    req_pct = 100; ready_pct = 100; resp_pct = 0; we_pct = 25;
    run(30);
    resp_pct = 100; req_pct = 60; we_pct = 30;
    run(20);

    // Exclusive lock toggling under load.
    lock_pct = 70; resp_pct = 50;
    run(200);
    lock_pct = 0;

    // Reset with reads outstanding: later responses become orphans.
    req_pct = 100; we_pct = 0; resp_pct = 0; ready_pct = 100;
    run(8);
    force_rst = 1'b1;
    run(1);
    force_rst = 1'b0;
    req_pct = 0; resp_pct = 100;
    run(10);

    // Random resets and spurious responses.
    req_pct = 60; we_pct = 30; ready_pct = 80; resp_pct = 50;
    spur_pct = 2; rst_permille = 10; lock_pct = 20;
    run(300);

    // Drain.
    spur_pct = 0; rst_permille = 0; lock_pct = 0; req_pct = 0; resp_pct = 100;
    run(40);
    @(negedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
